fpu_wb_arbiter: RTL
===================

Name: fpu_wb_arbiter

Overview:
- Owns the single write port (we3/a3/wd3) of the 15-entry FPU register file.
- Arbitrates writebacks from two requesters, the FPU execute unit and the FPU load path, using round-robin.
- Keeps a 15-bit pending-write scoreboard so the decode stage stalls on RAW/WAW hazards against in-flight FPU writes.
- Sits between FPU execute/memory writeback and fpuregfile. Index 15 is the bypassed r15 and is never tracked or written.

Parameters:
- NREG, 15, number of tracked FPU registers (indices 0..NREG-1); index 15 is excluded.
- DW, 32, writeback data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- issue_valid  in  1  decode presents an FPU-related instruction this cycle.
- issue_ra1  in  4  source register 1.
- issue_ra2  in  4  source register 2.
- issue_rd  in  4  destination register.
- issue_wr  in  1  instruction will write issue_rd.
- issue_stall  out  1  hold decode; the instruction is not accepted.
- fpu_valid  in  1  FPU result available.
- fpu_rd  in  4  FPU result destination.
- fpu_data  in  DW  FPU result value.
- fpu_ready  out  1  FPU result accepted this cycle.
- ld_valid  in  1  load data available.
- ld_rd  in  4  load destination.
- ld_data  in  DW  load value.
- ld_ready  out  1  load result accepted this cycle.
- we3  out  1  register file write enable (registered).
- a3  out  4  register file write address (registered).
- wd3  out  DW  register file write data (registered).

Behaviour:
- Reset (reset_n=0 at posedge): pending=0, we3=0, a3=0, wd3=0, rr_last=1 (load last granted, so the FPU wins the first tie).
  - Reset applied mid-operation discards any accepted but unwritten result.
- Arbitration (combinational in cycle N):
  - Only fpu_valid: grant FPU.
  - Only ld_valid: grant load.
  - Both valid: grant the requester not equal to rr_last.
  - Granted requester sees ready=1; the other sees ready=0 and must hold valid/rd/data stable.
  - rr_last updates to the granted requester on each grant.
- Write stage: the grant in cycle N registers into we3=1, a3=rd, wd3=data at posedge ending N. The write lands in fpuregfile one edge later.
  - Latency from valid to register-file update is 2 edges.
  - No grant in cycle N: we3=0 in N+1; a3/wd3 hold their previous values.
- Writes with rd=4'b1111: the requester is still granted and consumed, but we3 stays 0. No scoreboard change.
- Scoreboard set: in cycle N, if issue_valid & issue_wr & ~issue_stall & issue_rd!=15, pending[issue_rd] sets at the edge.
- Scoreboard clear: pending[a3] clears at the edge ending the cycle in which we3=1.
  - The dependent instruction issues the cycle after the write, so it reads the updated value.
- Same index set and cleared in one cycle: set wins. This is unreachable in normal flow because of the WAW stall.
- issue_stall (combinational) = issue_valid & ( pending[ra1] | pending[ra2] | (issue_wr & pending[rd]) ).
  - Any index 15 term contributes 0.
- A result arriving for a non-pending register is still written. Clear on a 0 bit is harmless.
- FPU and load both targeting the same rd in one cycle: serialise by round-robin; the later grant's data remains in the register.

Optional Feature:
- Macro FPU_WB_PERF_EN.
- Defined:
  - Adds output stall_cnt (16 bits), counting cycles with issue_stall=1.
  - Adds output conflict_cnt (16 bits), counting cycles with fpu_valid & ld_valid.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with all valids=1 -> we3=0, a3=0, wd3=0, issue_stall=0 the cycle after release.
- Single FPU write: issue rd=3 wr=1; next cycle fpu_valid, rd=3, data=32'h3F800000 -> fpu_ready=1; next cycle we3=1, a3=3, wd3=32'h3F800000; pending[3] clears after that edge.
- RAW stall: pending[5]=1, issue ra1=5 -> issue_stall=1 until the cycle after we3=1 with a3=5, then issue_stall=0.
- Conflict: fpu_valid (rd=1, data=32'h11) and ld_valid (rd=2, data=32'h22) held for 2 cycles from reset -> FPU granted first (a3=1), then load (a3=2).
  - Repeat the conflict -> grant alternates FPU, load.
- r15 handling: ld_valid rd=15 -> ld_ready=1, we3 stays 0; issue ra2=15 never stalls.
- Mid-operation reset: assert reset_n=0 while we3 is pending -> next cycle we3=0, pending=0, issue_stall=0.

Source files
------------

// File: rtl/fpu_wb_arbiter.sv
// fpu_wb_arbiter: round-robin owner of the FPU register file write port.
// Two writeback requesters (FPU execute, FPU load) share we3/a3/wd3, and a
// pending-write scoreboard stalls decode on RAW/WAW hazards. r15 is bypassed
// elsewhere: it is never tracked and never written.
// Optional build macro FPU_WB_PERF_EN adds saturating stall/conflict counters.
module fpu_wb_arbiter #(
    parameter int NREG = 15,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          reset_n,
`ifdef FPU_WB_PERF_EN
    output logic [15:0]   stall_cnt,
    output logic [15:0]   conflict_cnt,
`endif
    input  logic          issue_valid,
    input  logic [3:0]    issue_ra1,
    input  logic [3:0]    issue_ra2,
    input  logic [3:0]    issue_rd,
    input  logic          issue_wr,
    output logic          issue_stall,
    input  logic          fpu_valid,
    input  logic [3:0]    fpu_rd,
    input  logic [DW-1:0] fpu_data,
    output logic          fpu_ready,
    input  logic          ld_valid,
    input  logic [3:0]    ld_rd,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          we3,
    output logic [3:0]    a3,
    output logic [DW-1:0] wd3
);

    // Which requester won the most recent grant; the other one wins a tie.
    typedef enum logic {
        LAST_FPU = 1'b0,
        LAST_LD  = 1'b1
    } rr_t;

    rr_t            rr_last_reg, rr_last_next;
    logic [NREG-1:0] pending_reg, pending_next;
    logic           we3_reg, we3_next;
    logic [3:0]     a3_reg, a3_next;
    logic [DW-1:0]  wd3_reg, wd3_next;

    logic           grant_fpu;
    logic           grant_ld;
    logic           issue_accept;
    // Scoreboard widened to the full 4-bit index space; entries >= NREG
    // (including r15) read as never pending.
    logic [15:0]    pend16;

    genvar gi;

    generate
        for (gi = 0; gi < 16; gi++) begin : g_pend16
            if (gi < NREG) begin : g_trk
                assign pend16[gi] = pending_reg[gi];
            end else begin : g_untrk
                assign pend16[gi] = 1'b0;
            end
        end
    endgenerate

    assign issue_stall  = issue_valid & (pend16[issue_ra1] | pend16[issue_ra2] |
                                         (issue_wr & pend16[issue_rd]));
    assign issue_accept = issue_valid & issue_wr & ~issue_stall & (issue_rd != 4'hF);

    // Set on accepted issue, clear when the write port retires the index;
    // a set in the same cycle as a clear wins.
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_sb
            assign pending_next[gi] = (issue_accept & (issue_rd == 4'(gi))) |
                                      (pending_reg[gi] & ~(we3_reg & (a3_reg == 4'(gi))));
        end
    endgenerate

    // Round-robin grant and write-stage next values; r15 results are
    // consumed without touching the write port.
    always_comb begin
        grant_fpu    = fpu_valid & (~ld_valid | (rr_last_reg == LAST_LD));
        grant_ld     = ld_valid & (~fpu_valid | (rr_last_reg == LAST_FPU));
        rr_last_next = rr_last_reg;
        we3_next     = 1'b0;
        a3_next      = a3_reg;
        wd3_next     = wd3_reg;
        if (grant_fpu) begin
            rr_last_next = LAST_FPU;
            if (fpu_rd != 4'hF) begin
                we3_next = 1'b1;
                a3_next  = fpu_rd;
                wd3_next = fpu_data;
            end
        end else if (grant_ld) begin
            rr_last_next = LAST_LD;
            if (ld_rd != 4'hF) begin
                we3_next = 1'b1;
                a3_next  = ld_rd;
                wd3_next = ld_data;
            end
        end
    end

    assign fpu_ready = grant_fpu;
    assign ld_ready  = grant_ld;

    // State registers; reset drops any granted-but-unwritten result.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_last_reg <= LAST_LD;
            pending_reg <= '0;
            we3_reg     <= 1'b0;
            a3_reg      <= 4'd0;
            wd3_reg     <= '0;
        end else begin
            rr_last_reg <= rr_last_next;
            pending_reg <= pending_next;
            we3_reg     <= we3_next;
            a3_reg      <= a3_next;
            wd3_reg     <= wd3_next;
        end
    end

    assign we3 = we3_reg;
    assign a3  = a3_reg;
    assign wd3 = wd3_reg;

`ifdef FPU_WB_PERF_EN
    logic [15:0] stall_cnt_reg;
    logic [15:0] conflict_cnt_reg;

    // Saturating event counters for decode stalls and requester conflicts.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_reg    <= 16'd0;
            conflict_cnt_reg <= 16'd0;
        end else begin
            if (issue_stall && (stall_cnt_reg != 16'hFFFF))
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            if (fpu_valid && ld_valid && (conflict_cnt_reg != 16'hFFFF))
                conflict_cnt_reg <= conflict_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt    = stall_cnt_reg;
    assign conflict_cnt = conflict_cnt_reg;
`else
    // Performance counters not built.
`endif

endmodule
